ifetch_prefetch: RTL and testbench
==================================

# ifetch_prefetch

Instruction fetch unit with a small prefetch queue, sitting directly upstream of the unified instruction/data memory's instruction port and feeding the decode stage. It streams sequential word-aligned fetches into memory at up to one request per cycle, buffers the returned instruction words with their PCs, and presents them to decode over a valid/ready handshake. A redirect from execute, on a branch, jump or trap, flushes all buffered and in-flight fetches and restarts fetch at the new PC.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_addr  out  32  fetch byte address, always word-aligned.
- imem_read_en  out  1  fetch request this cycle.
- imem_read_data  in  32  fetched word, valid the cycle after a request.
- imem_ready  in  1  memory accepts requests; no request is issued while low.
- imem_fault  in  1  memory fault flag, sampled together with imem_read_data.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  restart address; bits [1:0] ignored (treated as 0).
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  instruction word at head.
- out_pc  out  32  PC of head.
- out_fault  out  1  head fetch faulted.

## Operation
- Reset values: imem_read_en=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_fault=0, queue empty, nothing in flight, fetch_pc=RESET_PC.
- Issue: imem_read_en=1 when imem_ready, no redirect_valid, not halted, and (occupancy + in_flight) < DEPTH. imem_addr=fetch_pc. On issue, fetch_pc += 4, wrapping modulo 2^32. The in_flight flag is set.
- Response: in the cycle after an issue, {fetch PC, imem_read_data, imem_fault} is written into the queue at the clock edge ending that cycle. The in_flight flag is then cleared unless a new issue occurred.
- Pop: out_valid && out_ready removes the head at the edge.
- Simultaneous push and pop: both take effect, and occupancy is unchanged. A full queue never receives a push, because the issue gating guarantees a slot.
- Redirect, which has priority over everything: the queue is cleared, the in-flight response is discarded, fetch_pc<=redirect_pc, and the halt is cleared. No issue occurs in the redirect cycle. A pop coincident with a redirect is not counted. out_valid=0 in the following cycle.
- Reset mid-operation clears all state asynchronously. Any memory response arriving after reset is discarded.

## Timing
- Issue to queue write: 1 cycle. Issue to out_valid: 2 cycles. Queue head is registered, with no bypass.
- After rst deasserts: first issue in cycle 0, out_valid in cycle 2.
- Redirect in cycle R: first issue at redirect_pc in R+1, out_valid in R+3.
- Steady state with out_ready=1: one instruction per cycle.
- out_ready=0: issue continues until occupancy plus in-flight reaches DEPTH, then stops. It resumes the cycle after a pop frees a slot.

## Configuration
- IFETCH_FAULT_EN defined:
  - a response with imem_fault=1 is queued with fault=1;
  - fetch halts, with no further issue until redirect;
  - out_fault reflects the head's fault bit.
- IFETCH_FAULT_EN undefined:
  - imem_fault is ignored, and the port stays present;
  - fault bits are not stored;
  - out_fault tied 0, and no halt state exists.

## Structure
- config_pkg gains the fetch_entry_t packed struct {pc[31:0], instr[31:0], fault}. It also gains the IFETCH_DEPTH default constant.
- Sub-module ifetch_fifo: a synchronous FIFO of fetch_entry_t with push, pop and flush, exposing count, full and empty. Flush wins over push and pop in the same cycle.
- The top level holds fetch_pc, the in_flight flag, the halt flag and the issue/credit logic.

## Test plan
- Reset with RESET_PC=0 and out_ready=1; memory words 0..3 = 11,22,33,44 → out_instr 11,22,33,44 on consecutive cycles from cycle 2, with out_pc 0,4,8,12.
- out_ready=0 for 10 cycles with DEPTH=4 → exactly 4 issues (addresses 0,4,8,12) and imem_read_en low afterwards. Raising out_ready → one pop per cycle and issue resumes at 16.
- Redirect to 32'h0000_0102 while the queue holds 3 entries and one is in flight → out_valid=0 next cycle. The next issue is to 0x100, and no stale entry ever appears at the output.
- fetch_pc=32'hFFFF_FFFC → the following issue address is 32'h0000_0000.
- With IFETCH_FAULT_EN, imem_fault=1 on the response to 0x8 → entry pc=0x8 out_fault=1 and no issues after it. A redirect to 0x40 clears the halt and resumes issue. Without the macro → out_fault stays 0 and fetch continues.
- Assert rst for one cycle mid-stream → all outputs return to reset values immediately. Refetch restarts at RESET_PC with out_valid two cycles after deassertion.

Source files
------------

// File: rtl/config_pkg.sv
// Shared fetch-path types and defaults for the instruction fetch unit.
package config_pkg;

    localparam int IFETCH_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries with a flush that
// dominates push and pop in the same cycle.
module ifetch_fifo
    import config_pkg::*;
#(
    parameter int DEPTH = IFETCH_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the top gates every head field with empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Sequential instruction fetch with a credit-gated prefetch queue and redirect flush.
// Define IFETCH_FAULT_EN to queue memory faults and halt fetch until the next redirect.
module ifetch_prefetch
    import config_pkg::*;
#(
    parameter int          DEPTH    = IFETCH_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_read_en,
    input  logic [31:0] imem_read_data,
    input  logic        imem_ready,
    input  logic        imem_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          in_flight;
    logic          issue;
    logic          push;
    logic          pop;
    logic          halt_now;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic          unused_bits;
    fetch_entry_t  resp;
    fetch_entry_t  head;

`ifdef IFETCH_FAULT_EN
    logic halted;

    // A faulting response blocks issue in the very cycle it is seen, so its PC is the last fetch.
    assign halt_now    = halted || (in_flight && imem_fault);
    assign resp        = '{pc: inflight_pc, instr: imem_read_data, fault: imem_fault};
    assign out_fault   = !empty && head.fault;
    assign unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     halted <= 1'b0;
        else if (redirect_valid)     halted <= 1'b0;
        else if (push && imem_fault) halted <= 1'b1;
    end
`else
    assign halt_now    = 1'b0;
    assign resp        = '{pc: inflight_pc, instr: imem_read_data, fault: 1'b0};
    assign out_fault   = 1'b0;
    assign unused_bits = ^{redirect_pc[1:0], imem_fault, head.fault};
`endif

    // Credits count the in-flight slot so a response always finds room.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, in_flight};
    assign issue = !rst && imem_ready && !redirect_valid && !halt_now && !full
                   && (occ < (CW+1)'(DEPTH));
    assign push  = in_flight && !redirect_valid;
    assign pop   = out_valid && out_ready;

    assign imem_read_en = issue;
    assign imem_addr    = fetch_pc;
    assign out_valid    = !empty;
    assign out_instr    = empty ? 32'h0 : head.instr;
    assign out_pc       = empty ? 32'h0 : head.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            inflight_pc <= '0;
            in_flight   <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) inflight_pc <= fetch_pc;
            if (redirect_valid) fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (issue)     fetch_pc <= fetch_pc + 32'd4;
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (resp),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with a one-cycle-latency memory model.
module tb_ifetch_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_read_en;
    logic [31:0] imem_read_data = '0;
    logic        imem_ready = 1'b1;
    logic        imem_fault = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    int          tests = 0;
    int          fails = 0;
    logic        fault_arm = 1'b0;
    logic [31:0] fault_addr = '0;

    always #5 clk = ~clk;

    ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_read_en   (imem_read_en),
        .imem_read_data (imem_read_data),
        .imem_ready     (imem_ready),
        .imem_fault     (imem_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'd11;
            32'd4:   return 32'd22;
            32'd8:   return 32'd33;
            32'd12:  return 32'd44;
            default: return a + 32'h1000_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        imem_read_data <= imem_read_en ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        imem_fault     <= imem_read_en && fault_arm && (imem_addr == fault_addr);
    end

    // Leaves the caller at the falling edge that starts cycle 0 after reset.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (imem_read_en !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0 ||
            out_instr !== 32'h0 || out_pc !== 32'h0 || out_fault !== 1'b0) begin
            fails++;
            $display("FAIL reset: rd_en=%b addr=%h valid=%b instr=%h pc=%h fault=%b expected all zero",
                     imem_read_en, imem_addr, out_valid, out_instr, out_pc, out_fault);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_i [4];
        exp_i[0] = 32'd11; exp_i[1] = 32'd22; exp_i[2] = 32'd33; exp_i[3] = 32'd44;
        out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            tests++;
            if (imem_read_en !== 1'b1 || imem_addr !== 32'(4 * c)) begin
                fails++;
                $display("FAIL stream_issue c%0d: rd_en=%b addr=%h expected 1 %h", c, imem_read_en, imem_addr, 32'(4 * c));
            end
            tests++;
            if (c < 2) begin
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL stream_valid c%0d: valid=%b expected 0", c, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_instr !== exp_i[c-2] || out_pc !== 32'(4 * (c - 2))) begin
                fails++;
                $display("FAIL stream_out c%0d: valid=%b instr=%h pc=%h expected 1 %h %h",
                         c, out_valid, out_instr, out_pc, exp_i[c-2], 32'(4 * (c - 2)));
            end
        end
    endtask

    task automatic test_backpressure();
        int          n_issue;
        logic [31:0] exp_i [4];
        exp_i[0] = 32'd11; exp_i[1] = 32'd22; exp_i[2] = 32'd33; exp_i[3] = 32'd44;
        n_issue = 0;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (imem_read_en) begin
                tests++;
                if (imem_addr !== 32'(4 * n_issue) || c >= 4) begin
                    fails++;
                    $display("FAIL bp_issue c%0d: addr=%h expected %h before c4", c, imem_addr, 32'(4 * n_issue));
                end
                n_issue++;
            end
        end
        tests++;
        if (n_issue != 4) begin
            fails++;
            $display("FAIL bp_count: issues=%0d expected 4", n_issue);
        end
        for (int c = 10; c < 14; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_instr !== exp_i[c-10] || out_pc !== 32'(4 * (c - 10))) begin
                fails++;
                $display("FAIL bp_drain c%0d: valid=%b instr=%h pc=%h expected 1 %h %h",
                         c, out_valid, out_instr, out_pc, exp_i[c-10], 32'(4 * (c - 10)));
            end
            tests++;
            if (c == 10 && imem_read_en !== 1'b0) begin
                fails++;
                $display("FAIL bp_resume c10: rd_en=%b expected 0", imem_read_en);
            end else if (c > 10 && (imem_read_en !== 1'b1 || imem_addr !== 32'(16 + 4 * (c - 11)))) begin
                fails++;
                $display("FAIL bp_resume c%0d: rd_en=%b addr=%h expected 1 %h", c, imem_read_en, imem_addr, 32'(16 + 4 * (c - 11)));
            end
        end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        // cycle 4: three queued, one in flight
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        out_ready = 1'b1;
        #1;
        tests++;
        if (imem_read_en !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL redir_cycle: rd_en=%b valid=%b expected 0 1", imem_read_en, out_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || imem_read_en !== 1'b1 || imem_addr !== 32'h100) begin
            fails++;
            $display("FAIL redir_next: valid=%b rd_en=%b addr=%h expected 0 1 00000100", out_valid, imem_read_en, imem_addr);
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_stale: valid=%b pc=%h expected 0", out_valid, out_pc);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'(32'h100 + 4 * k) || out_instr !== mem_word(32'(32'h100 + 4 * k))) begin
                fails++;
                $display("FAIL redir_out k%0d: valid=%b pc=%h instr=%h expected 1 %h", k, out_valid, out_pc, out_instr, 32'(32'h100 + 4 * k));
            end
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        tests++;
        if (imem_read_en !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL wrap_issue0: rd_en=%b addr=%h expected 1 fffffffc", imem_read_en, imem_addr);
        end
        @(negedge clk);
        #1;
        tests++;
        if (imem_read_en !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL wrap_issue1: rd_en=%b addr=%h expected 1 00000000", imem_read_en, imem_addr);
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h0FFF_FFFC) begin
            fails++;
            $display("FAIL wrap_out0: valid=%b pc=%h instr=%h expected 1 fffffffc 0ffffffc", out_valid, out_pc, out_instr);
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'd11) begin
            fails++;
            $display("FAIL wrap_out1: valid=%b pc=%h instr=%h expected 1 0 0000000b", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_fault();
        out_ready = 1'b1;
        fault_arm = 1'b1;
        fault_addr = 32'h8;
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        // cycle 3: response for 0x8 carries the fault
        tests++;
`ifdef IFETCH_FAULT_EN
        if (imem_read_en !== 1'b0) begin
            fails++;
            $display("FAIL fault_halt c3: rd_en=%b expected 0", imem_read_en);
        end
`else
        if (imem_read_en !== 1'b1 || imem_addr !== 32'hC) begin
            fails++;
            $display("FAIL fault_nohalt c3: rd_en=%b addr=%h expected 1 0000000c", imem_read_en, imem_addr);
        end
`endif
        fault_arm = 1'b0;
        @(negedge clk);
        #1;
        tests++;
`ifdef IFETCH_FAULT_EN
        if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_fault !== 1'b1 || imem_read_en !== 1'b0) begin
            fails++;
            $display("FAIL fault_entry: valid=%b pc=%h fault=%b rd_en=%b expected 1 8 1 0", out_valid, out_pc, out_fault, imem_read_en);
        end
`else
        if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_fault !== 1'b0 || imem_read_en !== 1'b1) begin
            fails++;
            $display("FAIL fault_entry: valid=%b pc=%h fault=%b rd_en=%b expected 1 8 0 1", out_valid, out_pc, out_fault, imem_read_en);
        end
`endif
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        tests++;
        if (imem_read_en !== 1'b1 || imem_addr !== 32'h40) begin
            fails++;
            $display("FAIL fault_resume: rd_en=%b addr=%h expected 1 00000040", imem_read_en, imem_addr);
        end
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_fault !== 1'b0) begin
            fails++;
            $display("FAIL fault_after: valid=%b pc=%h fault=%b expected 1 40 0", out_valid, out_pc, out_fault);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (imem_read_en !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0 ||
            out_instr !== 32'h0 || out_pc !== 32'h0 || out_fault !== 1'b0) begin
            fails++;
            $display("FAIL midrst: rd_en=%b addr=%h valid=%b instr=%h pc=%h expected 0 0 0 0 0",
                     imem_read_en, imem_addr, out_valid, out_instr, out_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (imem_read_en !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_c0: rd_en=%b addr=%h valid=%b expected 1 0 0", imem_read_en, imem_addr, out_valid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_c1: valid=%b pc=%h expected 0", out_valid, out_pc);
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'd11) begin
            fails++;
            $display("FAIL midrst_c2: valid=%b pc=%h instr=%h expected 1 0 0000000b", out_valid, out_pc, out_instr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fault();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
